sd_window_decimator: RTL and testbench



---
 rtl/sd_window_decimator_if.sv | 37 +++
 rtl/sd_window_decimator.sv | 161 ++++++++++++++++
 tb/tb_sd_window_decimator.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_window_decimator_if.sv
// rtl/sd_window_decimator_if.sv - stream/control/output bundle for sd_window_decimator
//
// Purpose: groups the bitstream inputs, run-time controls and decimated outputs
// of sd_window_decimator so the block and its producer/consumer share one port.
// Signals:
//   stream      CHANNELS bits   sigma-delta bitstreams, one bit per channel per clk
//   window      WIN_BITS        integration length (0 -> 1, >MAX_WINDOW -> MAX_WINDOW)
//   decim       DECIM_BITS      output every decim+1 clocks
//   value       CHANNELS*RES    saturated window sums, channel c at [c*RES +: RES]
//   value_valid 1               one-cycle strobe, value updated this cycle
//   filled      1               current window fully populated
// Modports: master drives stream/window/decim, slave (the decimator) drives outputs.
interface sd_window_decimator_if #(
  parameter int CHANNELS   = 2,
  parameter int RESOLUTION = 6,
  parameter int MAX_WINDOW = 128,
  parameter int DECIM_BITS = 4
);
  localparam int WIN_BITS = $clog2(MAX_WINDOW + 1);

  logic [CHANNELS-1:0]            stream;
  logic [WIN_BITS-1:0]            window;
  logic [DECIM_BITS-1:0]          decim;
  logic [CHANNELS*RESOLUTION-1:0] value;
  logic                           value_valid;
  logic                           filled;

  modport master (
    output stream, window, decim,
    input  value, value_valid, filled
  );

  modport slave (
    input  stream, window, decim,
    output value, value_valid, filled
  );
endinterface

// File: rtl/sd_window_decimator.sv
// rtl/sd_window_decimator.sv - multi-channel windowed sigma-delta integrator with saturating decimated output
//
// Purpose: each channel sums its 1-bit stream over the last W samples
// (W = clamp(window, 1, MAX_WINDOW)), saturates the sum to RESOLUTION bits
// and publishes it every decim+1 clocks once the window is full.
// Ports:
//   clk    sample clock
//   reset  asynchronous, active-high reset
//   bus    sd_window_decimator_if.slave (stream, window, decim in; value,
//          value_valid, filled out)
module sd_window_decimator #(
  parameter int CHANNELS   = 2,
  parameter int RESOLUTION = 6,
  parameter int MAX_WINDOW = 128,
  parameter int DECIM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sd_window_decimator_if.slave  bus
);

  localparam int WIN_BITS = $clog2(MAX_WINDOW + 1);
  localparam int PTR_BITS = (MAX_WINDOW > 1) ? $clog2(MAX_WINDOW) : 1;
  localparam logic [WIN_BITS-1:0]   MAX_W   = WIN_BITS'(MAX_WINDOW);
  localparam logic [PTR_BITS-1:0]   PTR_LAST = PTR_BITS'(MAX_WINDOW - 1);
  localparam logic [PTR_BITS-1:0]   PTR_MAX  = PTR_BITS'(MAX_WINDOW);
  localparam logic [WIN_BITS-1:0]   SAT_W    = WIN_BITS'((2 ** RESOLUTION) - 1);
  localparam logic [RESOLUTION-1:0] SAT_R    = '1;

  typedef enum logic {FILL, RUN} state_t;

  state_t                         state_q, state_d;
  logic [WIN_BITS-1:0]            w_eff;
  logic [WIN_BITS-1:0]            window_q;
  logic [WIN_BITS-1:0]            fill_cnt;
  logic [PTR_BITS-1:0]            wr_ptr, rd_ptr, w_lo;
  logic [DECIM_BITS-1:0]          dcnt, decim_q;
  logic [WIN_BITS-1:0]            sum_q [CHANNELS];
  logic [MAX_WINDOW-1:0]          hist  [CHANNELS];
  logic [CHANNELS-1:0]            outgoing;
  logic [CHANNELS*RESOLUTION-1:0] sat_sums;
  logic [CHANNELS*RESOLUTION-1:0] value_q;
  logic                           value_valid_q, filled_q;
  logic                           restart, fill_done, strobe;

  // Effective window, clamped into 1..MAX_WINDOW.
  always_comb begin
    w_eff = bus.window;
    if (bus.window == '0)
      w_eff = WIN_BITS'(1);
    else if (bus.window > MAX_W)
      w_eff = MAX_W;
  end

  // Outgoing bit sits W writes behind the write pointer. W == MAX_WINDOW
  // reads the slot about to be overwritten, which still holds the old bit.
  // The subtraction is done modulo 2^PTR_BITS; the true result is always
  // below MAX_WINDOW so the truncated arithmetic lands on the right slot.
  always_comb begin
    w_lo = (w_eff == MAX_W) ? '0 : w_eff[PTR_BITS-1:0];
    if (wr_ptr >= w_lo)
      rd_ptr = wr_ptr - w_lo;
    else
      rd_ptr = wr_ptr + PTR_MAX - w_lo;
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      outgoing[c] = hist[c][rd_ptr];
      sat_sums[c*RESOLUTION +: RESOLUTION] =
        (sum_q[c] > SAT_W) ? SAT_R : RESOLUTION'(sum_q[c]);
    end
  end

  // Next-state and per-cycle control. A window change overrides everything,
  // including a decimation wrap landing on the same cycle.
  always_comb begin
    state_d   = state_q;
    restart   = (w_eff != window_q);
    fill_done = 1'b0;
    strobe    = 1'b0;
    if (restart) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL: begin
          if (fill_cnt == w_eff - 1'b1) begin
            fill_done = 1'b1;
            state_d   = RUN;
          end
        end
        RUN: begin
          strobe = (dcnt >= decim_q);
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FILL;
      window_q      <= MAX_W;
      wr_ptr        <= '0;
      fill_cnt      <= '0;
      dcnt          <= '0;
      decim_q       <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      filled_q      <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) sum_q[c] <= '0;
    end else begin
      state_q <= state_d;
      if (restart) begin
        // The sample on this cycle is dropped; value keeps its last contents.
        window_q      <= w_eff;
        fill_cnt      <= '0;
        dcnt          <= '0;
        decim_q       <= bus.decim;
        value_valid_q <= 1'b0;
        filled_q      <= 1'b0;
        for (int c = 0; c < CHANNELS; c++) sum_q[c] <= '0;
      end else begin
        wr_ptr        <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        value_valid_q <= strobe;
        for (int c = 0; c < CHANNELS; c++) begin
          if (state_q == FILL)
            sum_q[c] <= sum_q[c] + WIN_BITS'(bus.stream[c]);
          else
            sum_q[c] <= sum_q[c] + WIN_BITS'(bus.stream[c]) - WIN_BITS'(outgoing[c]);
        end
        if (state_q == FILL) begin
          // decim is tracked while filling so the first RUN period uses it.
          fill_cnt <= fill_cnt + 1'b1;
          dcnt     <= '0;
          decim_q  <= bus.decim;
          if (fill_done) filled_q <= 1'b1;
        end else if (strobe) begin
          // Value is the sum before this cycle's bit: one clock of latency.
          dcnt    <= '0;
          decim_q <= bus.decim;
          value_q <= sat_sums;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end
    end
  end

  // History needs no reset: FILL never subtracts, so stale bits are never read.
  always_ff @(posedge clk) begin
    if (!restart) begin
      for (int c = 0; c < CHANNELS; c++) hist[c][wr_ptr] <= bus.stream[c];
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.filled      = filled_q;

endmodule

// File: tb/tb_sd_window_decimator.sv
// tb/tb_sd_window_decimator.sv - self-checking bench for sd_window_decimator
module tb_sd_window_decimator;
  localparam int CH   = 2;
  localparam int RES  = 6;
  localparam int MAXW = 128;
  localparam int DB   = 4;
  localparam int SATV = (2 ** RES) - 1;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  sd_window_decimator_if #(.CHANNELS(CH), .RESOLUTION(RES), .MAX_WINDOW(MAXW), .DECIM_BITS(DB)) bus ();

  sd_window_decimator #(.CHANNELS(CH), .RESOLUTION(RES), .MAX_WINDOW(MAXW), .DECIM_BITS(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reference model: keeps the accepted samples of the current window as a
  // queue and sums it directly whenever a strobe is due.
  int                model_w;
  logic [CH-1:0]     hq[$];
  int                m_dcnt, m_dq;
  logic [CH*RES-1:0] m_value;
  logic              m_valid, m_filled;

  function automatic int eff_w(int w);
    if (w == 0) return 1;
    if (w > MAXW) return MAXW;
    return w;
  endfunction

  function automatic logic [CH*RES-1:0] window_sat();
    logic [CH*RES-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      int s;
      s = 0;
      foreach (hq[i]) s += int'(hq[i][c]);
      if (s > SATV) s = SATV;
      r[c*RES +: RES] = RES'(s);
    end
    return r;
  endfunction

  task automatic model_reset();
    model_w  = MAXW;
    hq.delete();
    m_dcnt   = 0;
    m_dq     = 0;
    m_value  = '0;
    m_valid  = 1'b0;
    m_filled = 1'b0;
  endtask

  task automatic model_step();
    int w;
    w = eff_w(int'(bus.window));
    if (reset) begin
      model_reset();
      return;
    end
    if (w != model_w) begin
      model_w  = w;
      hq.delete();
      m_valid  = 1'b0;
      m_filled = 1'b0;
      m_dcnt   = 0;
      m_dq     = int'(bus.decim);
      return;
    end
    if (m_filled) begin
      if (m_dcnt == m_dq) begin
        m_value = window_sat();
        m_valid = 1'b1;
        m_dcnt  = 0;
        m_dq    = int'(bus.decim);
      end else begin
        m_valid = 1'b0;
        m_dcnt++;
      end
    end else begin
      m_valid = 1'b0;
      m_dq    = int'(bus.decim);
    end
    hq.push_back(bus.stream);
    if (hq.size() > w) void'(hq.pop_front());
    if (hq.size() == w) m_filled = 1'b1;
  endtask

  // One clock: model follows the DUT at the active edge, outputs are then
  // observed at the falling edge where the bench also drives new inputs.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.stream  = '0;
    bus.window  = 8'd16;
    bus.decim   = '0;
    model_reset();
    tick();
    tick();
    total++;
    if ({bus.value, bus.value_valid, bus.filled} !== '0)
      begin bad++; $display("FAIL reset_state: got %h want 0", {bus.value, bus.value_valid, bus.filled}); end
    reset = 1'b0;
  endtask

  task automatic test_fill16();
    int first_fill;
    first_fill = 0;
    bus.stream = 2'b01;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.filled && first_fill == 0) first_fill = k;
      total++;
      if ({bus.value, bus.value_valid, bus.filled} !== {m_value, m_valid, m_filled})
        begin bad++; $display("FAIL fill16 k=%0d: got %h want %h", k, {bus.value, bus.value_valid, bus.filled}, {m_value, m_valid, m_filled}); end
      if (k == 18) begin
        total++;
        if ({bus.value, bus.value_valid} !== {6'd0, 6'd16, 1'b1})
          begin bad++; $display("FAIL fill16_first_strobe: got %h want %h", {bus.value, bus.value_valid}, {6'd0, 6'd16, 1'b1}); end
      end
    end
    total++;
    if (first_fill !== 17)
      begin bad++; $display("FAIL fill16_filled_rise: got tick %0d want tick 17", first_fill); end
  endtask

  task automatic test_saturation();
    bus.window = 8'd110;
    bus.decim  = 4'd0;
    for (int k = 0; k < 130; k++) begin
      bus.stream = {1'($urandom), 1'b1};
      tick();
      total++;
      if ({bus.value, bus.value_valid, bus.filled} !== {m_value, m_valid, m_filled})
        begin bad++; $display("FAIL saturation k=%0d: got %h want %h", k, {bus.value, bus.value_valid, bus.filled}, {m_value, m_valid, m_filled}); end
    end
    total++;
    if (bus.value[0 +: RES] !== 6'd63)
      begin bad++; $display("FAIL saturation_ch0: got %0d want 63", bus.value[0 +: RES]); end
  endtask

  task automatic test_decim();
    int strobes;
    strobes = 0;
    bus.window = 8'd16;
    bus.decim  = 4'd3;
    for (int k = 0; k < 60; k++) begin
      bus.stream = {1'($urandom), 1'(k % 2)};
      tick();
      total++;
      if ({bus.value, bus.value_valid, bus.filled} !== {m_value, m_valid, m_filled})
        begin bad++; $display("FAIL decim k=%0d: got %h want %h", k, {bus.value, bus.value_valid, bus.filled}, {m_value, m_valid, m_filled}); end
      if (k >= 20 && bus.value_valid) begin
        strobes++;
        total++;
        if (bus.value[0 +: RES] !== 6'd8)
          begin bad++; $display("FAIL decim_alt_sum k=%0d: got %0d want 8", k, bus.value[0 +: RES]); end
      end
    end
    total++;
    if (strobes !== 10)
      begin bad++; $display("FAIL decim_rate: got %0d strobes want 10", strobes); end
  endtask

  task automatic test_window_change();
    bus.decim  = 4'd0;
    bus.stream = 2'b11;
    for (int k = 0; k < 25; k++) tick();
    total++;
    if ({bus.value, bus.value_valid, bus.filled} !== {6'd16, 6'd16, 1'b1, 1'b1})
      begin bad++; $display("FAIL wchange_before: got %h want %h", {bus.value, bus.value_valid, bus.filled}, {6'd16, 6'd16, 1'b1, 1'b1}); end
    bus.window = 8'd32;
    tick();
    total++;
    if ({bus.value, bus.value_valid, bus.filled} !== {6'd16, 6'd16, 1'b0, 1'b0})
      begin bad++; $display("FAIL wchange_restart: got %h want %h", {bus.value, bus.value_valid, bus.filled}, {6'd16, 6'd16, 1'b0, 1'b0}); end
    for (int k = 1; k <= 33; k++) begin
      tick();
      total++;
      if ({bus.value, bus.value_valid, bus.filled} !== {m_value, m_valid, m_filled})
        begin bad++; $display("FAIL wchange k=%0d: got %h want %h", k, {bus.value, bus.value_valid, bus.filled}, {m_value, m_valid, m_filled}); end
    end
    total++;
    if ({bus.value, bus.value_valid} !== {6'd32, 6'd32, 1'b1})
      begin bad++; $display("FAIL wchange_after: got %h want %h", {bus.value, bus.value_valid}, {6'd32, 6'd32, 1'b1}); end
  endtask

  task automatic test_window_clamp();
    logic [CH-1:0] prev;
    logic [CH-1:0] cur;
    cur = '0;
    bus.window = 8'd0;
    bus.decim  = 4'd0;
    for (int k = 0; k < 40; k++) begin
      prev = cur;
      cur  = CH'($urandom);
      bus.stream = cur;
      tick();
      total++;
      if ({bus.value, bus.value_valid, bus.filled} !== {m_value, m_valid, m_filled})
        begin bad++; $display("FAIL clamp0 k=%0d: got %h want %h", k, {bus.value, bus.value_valid, bus.filled}, {m_value, m_valid, m_filled}); end
      if (k >= 3) begin
        total++;
        if ({bus.value[RES +: RES], bus.value[0 +: RES]} !== {5'd0, prev[1], 5'd0, prev[0]})
          begin bad++; $display("FAIL clamp0_prev_bit k=%0d: got %h want %h", k, bus.value, {5'd0, prev[1], 5'd0, prev[0]}); end
      end
    end
    bus.window = 8'd200;
    bus.stream = 2'b01;
    for (int k = 0; k < 140; k++) tick();
    total++;
    if ({bus.value, bus.filled} !== {6'd0, 6'd63, 1'b1})
      begin bad++; $display("FAIL clamp200: got %h want %h", {bus.value, bus.filled}, {6'd0, 6'd63, 1'b1}); end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 6; seg++) begin
      bus.window = 8'($urandom_range(0, 140));
      bus.decim  = 4'($urandom_range(0, 15));
      for (int k = 0; k < 160; k++) begin
        if (k % 37 == 36) bus.decim = 4'($urandom_range(0, 15));
        bus.stream = CH'($urandom);
        if ($urandom_range(0, 3) != 0) bus.stream = {bus.stream[1], 1'b1};
        tick();
        total++;
        if ({bus.value, bus.value_valid, bus.filled} !== {m_value, m_valid, m_filled})
          begin bad++; $display("FAIL random seg=%0d k=%0d w=%0d: got %h want %h", seg, k, bus.window, {bus.value, bus.value_valid, bus.filled}, {m_value, m_valid, m_filled}); end
      end
    end
  endtask

  task automatic test_async_reset();
    int early;
    early = 0;
    bus.window = 8'd16;
    bus.decim  = 4'd1;
    bus.stream = 2'b11;
    for (int k = 0; k < 40; k++) tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    total++;
    if ({bus.value, bus.value_valid, bus.filled} !== '0)
      begin bad++; $display("FAIL async_reset: got %h want 0", {bus.value, bus.value_valid, bus.filled}); end
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k <= 17 && bus.value_valid) early++;
      total++;
      if ({bus.value, bus.value_valid, bus.filled} !== {m_value, m_valid, m_filled})
        begin bad++; $display("FAIL post_reset k=%0d: got %h want %h", k, {bus.value, bus.value_valid, bus.filled}, {m_value, m_valid, m_filled}); end
    end
    total++;
    if (early !== 0)
      begin bad++; $display("FAIL post_reset_no_early_strobe: got %0d strobes want 0", early); end
  endtask

  initial begin
    test_reset();
    test_fill16();
    test_saturation();
    test_decim();
    test_window_change();
    test_window_clamp();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
